branch_predictor_btb: RTL and testbench

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

---
 rtl/branch_predictor_btb_pkg.sv | 20 ++
 rtl/sat_counter_update.sv | 19 +
 rtl/branch_predictor_btb.sv | 122 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants for the fetch-stage branch predictor: ISA word size,
// control-flow opcode/function codes and the predictor FSM encoding.
package branch_predictor_btb_pkg;

  localparam int unsigned BP_WORD_SIZE = 16;

  localparam logic [3:0] OP_BNE = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1001;
  localparam logic [3:0] OP_BGZ = 4'b1010;
  localparam logic [3:0] OP_BLZ = 4'b1011;

  localparam logic [3:0] FN_JPR = 4'b0100;
  localparam logic [3:0] FN_JRL = 4'b0101;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } btb_state_e;

endpackage

// File: rtl/sat_counter_update.sv
// Next value of a saturating up/down prediction counter.
module sat_counter_update #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] count,
  input  logic                taken,
  output logic [CTR_BITS-1:0] next_count
);

  always_comb begin
    next_count = count;
    if (taken) begin
      if (count != '1) next_count = count + CTR_BITS'(1);
    end else begin
      if (count != '0) next_count = count - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Branch target buffer with bimodal or gshare direction counters; combinational
// lookup, single-cycle update, and a post-reset sweep clearing valid/counters.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = BP_WORD_SIZE,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HIST_BITS  = 4,
  parameter int unsigned MODE       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] next_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_hist,
  output logic                 ready,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_is_cond,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic [HIST_BITS-1:0] upd_hist
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [INDEX_BITS-1:0] PTR_LAST  = INDEX_BITS'(ENTRIES - 1);

  btb_state_e state, state_next;
  logic                  sweep_en;
  logic [INDEX_BITS-1:0] ptr;
  logic [HIST_BITS-1:0]  hist;

  logic [ENTRIES-1:0]    valid;
  logic [CTR_BITS-1:0]   ctr        [ENTRIES];
  logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
  logic [WORD_SIZE-1:0]  target_mem [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, lk_ctr_idx, upd_idx, upd_ctr_idx;
  logic [TAG_BITS-1:0]   lk_tag, upd_tag;
  logic [CTR_BITS-1:0]   lk_ctr, sat_next, ctr_wr;
  logic                  upd_en;

  // gshare folds the global history into the counter index only; the BTB stays PC-indexed.
  assign lk_idx      = pc[INDEX_BITS-1:0];
  assign lk_tag      = pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign lk_ctr_idx  = (MODE == 1) ? (lk_idx ^ INDEX_BITS'(hist)) : lk_idx;
  assign upd_idx     = upd_pc[INDEX_BITS-1:0];
  assign upd_tag     = upd_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign upd_ctr_idx = (MODE == 1) ? (upd_idx ^ INDEX_BITS'(upd_hist)) : upd_idx;

  assign lk_ctr     = ctr[lk_ctr_idx];
  assign ready      = (state == ST_RUN);
  assign pred_taken = ready && valid[lk_idx] && (tag_mem[lk_idx] == lk_tag)
                      && lk_ctr[CTR_BITS-1];
  assign next_pc    = pred_taken ? target_mem[lk_idx] : pc + WORD_SIZE'(1);
  assign pred_hist  = hist;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sweep_en   = 1'b0;
    case (state)
      ST_INIT: begin
        sweep_en = 1'b1;
        if (ptr == PTR_LAST) state_next = ST_RUN;
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  assign upd_en = ready && upd_valid;

  always_ff @(posedge clk) begin
    if (reset)         ptr <= '0;
    else if (sweep_en) ptr <= ptr + INDEX_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)                           hist <= '0;
    else if (upd_en && upd_is_cond)      hist <= HIST_BITS'({hist, upd_taken});
  end

  sat_counter_update #(.CTR_BITS(CTR_BITS)) u_sat (
    .count      (ctr[upd_ctr_idx]),
    .taken      (upd_taken),
    .next_count (sat_next)
  );

  // Jumps are always taken, so their counter is pinned at strongly-taken.
  assign ctr_wr = upd_is_cond ? sat_next : CTR_MAX;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (sweep_en) begin
        valid[ptr] <= 1'b0;
        ctr[ptr]   <= CTR_WEAK_NT;
      end else if (upd_en) begin
        ctr[upd_ctr_idx] <= ctr_wr;
        if (upd_taken) valid[upd_idx] <= 1'b1;
      end
    end
  end

  // Tag/target payload needs no reset: it is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (!reset && upd_en && upd_taken) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: bimodal and gshare instances share stimulus.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        upd_valid, upd_is_cond, upd_taken;
  logic [15:0] upd_pc, upd_target;
  logic [3:0]  upd_hist;

  logic [15:0] next_pc0, next_pc1;
  logic        pred_taken0, pred_taken1, ready0, ready1;
  logic [3:0]  pred_hist0, pred_hist1;

  always #5 clk = ~clk;

  branch_predictor_btb #(.MODE(0)) dut0 (
    .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc0), .pred_taken(pred_taken0),
    .pred_hist(pred_hist0), .ready(ready0), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_cond(upd_is_cond), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_hist(upd_hist)
  );

  branch_predictor_btb #(.MODE(1)) dut1 (
    .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc1), .pred_taken(pred_taken1),
    .pred_hist(pred_hist1), .ready(ready1), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_cond(upd_is_cond), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_hist(upd_hist)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp_next;
    logic        exp_taken;
    logic [3:0]  exp_hist;
  } sb_t;

  sb_t        sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] hist_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus; expectations for the lookup are queued per selected instance.
  task automatic drive(input logic [15:0] p, input logic uv, input logic [15:0] upc,
                       input logic cond, input logic tk, input logic [15:0] tgt,
                       input logic [3:0] uh, input int sel, input logic [15:0] exp_next,
                       input logic exp_tk, input string tag);
    sb_t e;
    @(posedge clk); #1;
    pc = p; upd_valid = uv; upd_pc = upc; upd_is_cond = cond;
    upd_taken = tk; upd_target = tgt; upd_hist = uh;
    for (int d = 0; d < 2; d++) begin
      if (sel[d]) begin
        e.tag = tag; e.sel = d; e.exp_next = exp_next;
        e.exp_taken = exp_tk; e.exp_hist = hist_m;
        sb.push_back(e);
      end
    end
    if (uv && cond && ready0 && !reset) hist_m = {hist_m[2:0], tk};
  endtask

  task automatic lookup(input int sel, input logic [15:0] p, input logic [15:0] exp_next,
                        input logic exp_tk, input string tag);
    drive(p, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, sel, exp_next, exp_tk, tag);
  endtask

  task automatic upd(input logic [15:0] a, input logic cond, input logic tk,
                     input logic [15:0] tgt, input logic [3:0] uh);
    drive(16'h0, 1'b1, a, cond, tk, tgt, uh, 0, 16'h0, 1'b0, "");
  endtask

  task automatic set_hist(input logic [3:0] h);
    for (int i = 3; i >= 0; i--) upd(16'h00F0, 1'b1, h[i], 16'h00F8, 4'h0);
  endtask

  // Reset with a concurrent taken update that must be ignored.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; hist_m = 4'h0;
    pc = 16'h0010; upd_valid = 1'b1; upd_pc = 16'h0010; upd_is_cond = 1'b1;
    upd_taken = 1'b1; upd_target = 16'h0999; upd_hist = 4'h0;
    drive(16'h0010, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0999, 4'h0, 3, 16'h0011, 1'b0, "rst_lookup");
    check_eq("rst_ready", 32'(ready0), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    for (n = 1; n <= 600; n++) begin
      drive(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 3, 16'h0011, 1'b0, "sweep");
      if (ready0) break;
    end
    check_eq({tag, "_cycles"}, 32'(n), 32'd256);
    check_eq({tag, "_ready1"}, 32'(ready1), 32'd1);
  endtask

  always @(negedge clk) begin
    sb_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel == 0) begin
        check_eq({e.tag, "_next0"},  32'(next_pc0),    32'(e.exp_next));
        check_eq({e.tag, "_taken0"}, 32'(pred_taken0), 32'(e.exp_taken));
        check_eq({e.tag, "_hist0"},  32'(pred_hist0),  32'(e.exp_hist));
      end else begin
        check_eq({e.tag, "_next1"},  32'(next_pc1),    32'(e.exp_next));
        check_eq({e.tag, "_taken1"}, 32'(pred_taken1), 32'(e.exp_taken));
        check_eq({e.tag, "_hist1"},  32'(pred_hist1),  32'(e.exp_hist));
      end
    end
  end

  initial begin
    reset = 1'b0; pc = 16'h0; upd_valid = 1'b0; upd_pc = 16'h0; upd_is_cond = 1'b0;
    upd_taken = 1'b0; upd_target = 16'h0; upd_hist = 4'h0; hist_m = 4'h0;

    do_reset();
    wait_ready("init");

    // Bimodal training and untraining
    repeat (2) upd(16'h0123, 1'b1, 1'b1, 16'h0150, 4'h0);
    lookup(1, 16'h0123, 16'h0150, 1'b1, "m0_taken");
    repeat (2) upd(16'h0123, 1'b1, 1'b0, 16'h0150, 4'h0);
    lookup(1, 16'h0123, 16'h0124, 1'b0, "m0_not_taken");

    // Saturation at both ends
    repeat (5) upd(16'h0040, 1'b1, 1'b1, 16'h0045, 4'h0);
    upd(16'h0040, 1'b1, 1'b0, 16'h0045, 4'h0);
    lookup(1, 16'h0040, 16'h0045, 1'b1, "sat_hi");
    repeat (3) upd(16'h0040, 1'b1, 1'b0, 16'h0045, 4'h0);
    lookup(1, 16'h0040, 16'h0041, 1'b0, "sat_lo");
    upd(16'h0040, 1'b1, 1'b1, 16'h0045, 4'h0);
    lookup(1, 16'h0040, 16'h0041, 1'b0, "sat_lo_inc1");
    upd(16'h0040, 1'b1, 1'b1, 16'h0045, 4'h0);
    lookup(1, 16'h0040, 16'h0045, 1'b1, "sat_lo_inc2");

    // Aliasing on index 0x23
    upd(16'h0123, 1'b1, 1'b1, 16'h0150, 4'h0);
    lookup(1, 16'h0223, 16'h0224, 1'b0, "alias_miss");
    lookup(1, 16'h0123, 16'h0150, 1'b1, "alias_orig");
    upd(16'h0223, 1'b1, 1'b1, 16'h0300, 4'h0);
    lookup(1, 16'h0223, 16'h0300, 1'b1, "alias_new");
    lookup(1, 16'h0123, 16'h0124, 1'b0, "alias_evicted");

    // Same-cycle lookup and install
    drive(16'h0077, 1'b1, 16'h0077, 1'b1, 1'b1, 16'h0200, 4'h0, 1, 16'h0078, 1'b0, "same_cycle");
    lookup(1, 16'h0077, 16'h0200, 1'b1, "same_cycle_next");

    // Unconditional jump pins counter at max
    upd(16'h0090, 1'b0, 1'b1, 16'h0500, 4'h0);
    lookup(1, 16'h0090, 16'h0500, 1'b1, "jump");
    upd(16'h0090, 1'b1, 1'b0, 16'h0500, 4'h0);
    lookup(1, 16'h0090, 16'h0500, 1'b1, "jump_forced_max");

    // gshare: separate counters per history for pc 0x0008
    repeat (2) upd(16'h0008, 1'b1, 1'b1, 16'h0088, 4'b1010);
    set_hist(4'b1010);
    lookup(2, 16'h0008, 16'h0088, 1'b1, "gshare_1010");
    set_hist(4'b0101);
    lookup(2, 16'h0008, 16'h0009, 1'b0, "gshare_0101");
    lookup(1, 16'h0008, 16'h0088, 1'b1, "bimodal_ignores_hist");

    // Reset in the middle of a sweep restarts it
    do_reset();
    repeat (100) lookup(0, 16'h0010, 16'h0, 1'b0, "");
    check_eq("mid_sweep_ready", 32'(ready0), 32'd0);
    do_reset();
    wait_ready("resweep");
    lookup(1, 16'h0223, 16'h0224, 1'b0, "post_reset_cleared");
    lookup(3, 16'h0090, 16'h0091, 1'b0, "post_reset_jump_cleared");

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
